timers_gen_nch: RTL and testbench

//  Parametrised multi-channel timer/counter. Successor to the fixed 3-byte timer0: NUM_CH independent

---
 rtl/timers_gen_nch.sv | 127 ++++++++++++
 tb/tb_timers_gen_nch.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timers_gen_nch.sv
// Multi-channel timer/counter: NUM_CH channels of WIDTH bits sharing one prescaler, each with
// timer/counter source, gate input and free-run / auto-reload / one-shot overflow behaviour.
module timers_gen_nch #(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 12
) (
    input  logic                      timers_clock_i,
    input  logic                      timers_reset_i,
    input  logic [NUM_CH-1:0]         timers_int_i,
    input  logic [NUM_CH-1:0]         timers_tx_i,
    input  logic [NUM_CH-1:0]         timers_sfr_gate_i,
    input  logic [NUM_CH-1:0]         timers_sfr_ct_i,
    input  logic [2*NUM_CH-1:0]       timers_sfr_mode_i,
    input  logic [NUM_CH-1:0]         timers_sfr_tr_i,
    input  logic [NUM_CH-1:0]         timers_sfr_load_i,
    input  logic [NUM_CH*WIDTH-1:0]   timers_sfr_cnt_i,
    input  logic [NUM_CH*WIDTH-1:0]   timers_sfr_reload_i,
    input  logic [NUM_CH-1:0]         timers_sfr_tf_clr_i,
    output logic [NUM_CH*WIDTH-1:0]   timers_sfr_cnt_o,
    output logic [NUM_CH-1:0]         timers_sfr_tf_o,
    output logic                      timers_irq_o
);

    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_RELOAD   = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_FREE_ALT = 2'b11
    } mode_e;

    localparam int                PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  CNT_ONES   = '1;
    localparam logic [WIDTH-1:0]  CNT_ONE    = WIDTH'(1);

    logic [PW-1:0]                   presc_q, presc_d;
    logic                            tick;
    logic [NUM_CH-1:0]               int_meta_q, int_sync_q;
    logic [NUM_CH-1:0]               tx_meta_q, tx_sync_q, tx_prev_q;
    logic [NUM_CH-1:0]               tx_fall;
    logic [NUM_CH-1:0][WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]               tf_q, tf_d;
    logic [NUM_CH-1:0]               done_q, done_d;
    logic [NUM_CH-1:0]               run, evt, ovf;
    logic                            irq_q;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    assign tx_fall = tx_prev_q & ~tx_sync_q;

    // Load beats any counting event; an overflow flag set beats a same-edge clear.
    always_comb begin
        cnt_d  = cnt_q;
        tf_d   = tf_q;
        done_d = done_q;
        run    = '0;
        evt    = '0;
        ovf    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            run[k] = timers_sfr_tr_i[k] & ~done_q[k] & (~timers_sfr_gate_i[k] | int_sync_q[k]);
            evt[k] = run[k] & (timers_sfr_ct_i[k] ? tx_fall[k] : tick);
            if (timers_sfr_load_i[k]) begin
                cnt_d[k]  = timers_sfr_cnt_i[k*WIDTH +: WIDTH];
                done_d[k] = 1'b0;
            end else begin
                if (!timers_sfr_tr_i[k]) begin
                    done_d[k] = 1'b0;
                end
                if (evt[k]) begin
                    if (cnt_q[k] != CNT_ONES) begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end else begin
                        ovf[k] = 1'b1;
                        case (mode_e'(timers_sfr_mode_i[2*k +: 2]))
                            MODE_RELOAD: cnt_d[k] = timers_sfr_reload_i[k*WIDTH +: WIDTH];
                            MODE_ONESHOT: begin
                                cnt_d[k]  = '0;
                                done_d[k] = 1'b1;
                            end
                            default: cnt_d[k] = '0;
                        endcase
                    end
                end
            end
            if (ovf[k]) begin
                tf_d[k] = 1'b1;
            end else if (timers_sfr_tf_clr_i[k]) begin
                tf_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge timers_clock_i) begin
        if (timers_reset_i) begin
            presc_q    <= '0;
            int_meta_q <= '0;
            int_sync_q <= '0;
            tx_meta_q  <= '0;
            tx_sync_q  <= '0;
            tx_prev_q  <= '0;
            cnt_q      <= '0;
            tf_q       <= '0;
            done_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            int_meta_q <= timers_int_i;
            int_sync_q <= int_meta_q;
            tx_meta_q  <= timers_tx_i;
            tx_sync_q  <= tx_meta_q;
            tx_prev_q  <= tx_sync_q;
            cnt_q      <= cnt_d;
            tf_q       <= tf_d;
            done_q     <= done_d;
            irq_q      <= |tf_q;
        end
    end

    assign timers_sfr_cnt_o = cnt_q;
    assign timers_sfr_tf_o  = tf_q;
    assign timers_irq_o     = irq_q;

endmodule

// File: tb/tb_timers_gen_nch.sv
// Scoreboard bench for timers_gen_nch: dutA uses PRESCALE=12, dutB uses PRESCALE=1 for the
// tx-counter scenarios; both share the same stimulus.
module tb_timers_gen_nch;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  intPin, txPin, gate, ct, tr, load, tfClr;
    logic [3:0]  mode;
    logic [31:0] cntIn, reloadIn;
    logic [31:0] cntA, cntB;
    logic [1:0]  tfA, tfB;
    logic        irqA, irqB;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    // Clocks since reset release; dutA ticks on the edge that makes cyc a multiple of 12.
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    timers_gen_nch #(.NUM_CH(2), .WIDTH(16), .PRESCALE(12)) dutA (
        .timers_clock_i(clock), .timers_reset_i(reset),
        .timers_int_i(intPin), .timers_tx_i(txPin),
        .timers_sfr_gate_i(gate), .timers_sfr_ct_i(ct), .timers_sfr_mode_i(mode),
        .timers_sfr_tr_i(tr), .timers_sfr_load_i(load),
        .timers_sfr_cnt_i(cntIn), .timers_sfr_reload_i(reloadIn),
        .timers_sfr_tf_clr_i(tfClr),
        .timers_sfr_cnt_o(cntA), .timers_sfr_tf_o(tfA), .timers_irq_o(irqA)
    );

    timers_gen_nch #(.NUM_CH(2), .WIDTH(16), .PRESCALE(1)) dutB (
        .timers_clock_i(clock), .timers_reset_i(reset),
        .timers_int_i(intPin), .timers_tx_i(txPin),
        .timers_sfr_gate_i(gate), .timers_sfr_ct_i(ct), .timers_sfr_mode_i(mode),
        .timers_sfr_tr_i(tr), .timers_sfr_load_i(load),
        .timers_sfr_cnt_i(cntIn), .timers_sfr_reload_i(reloadIn),
        .timers_sfr_tf_clr_i(tfClr),
        .timers_sfr_cnt_o(cntB), .timers_sfr_tf_o(tfB), .timers_irq_o(irqB)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_phase(input int p);
        while (cyc % 12 != p) @(negedge clock);
    endtask

    task automatic push_exp(input string n, input logic [31:0] v);
        exp_t e;
        e.name  = n;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        exp_t e;
        reset = 1'b1; tr = 2'b11; load = 2'b11; cntIn = 32'h5678_1234;
        push_exp("rst_cntA", 32'h0); push_exp("rst_tfA", 32'h0);
        push_exp("rst_irqA", 32'h0); push_exp("rst_cntB", 32'h0);
        step(3);
        obs = cntA; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {30'h0, tfA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, irqA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = cntB; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end

        reset = 1'b0; load = 2'b00; tr = 2'b01; mode = 4'b0000;
        push_exp("t1_before_first_tick", 32'h0);
        step(11);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t1_first_tick", 32'h1);
        step(1);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t1_hold_between_ticks", 32'h1);
        step(11);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t1_second_tick", 32'h2);
        step(1);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
    endtask

    task automatic test_free_run_overflow();
        logic [31:0] obs;
        exp_t e;
        tr = 2'b00;
        wait_phase(11);
        load = 2'b01; cntIn[15:0] = 16'hFFF0;
        step(1);
        load = 2'b00; tr = 2'b01;
        push_exp("t2_cnt_ffff", 32'hFFFF); push_exp("t2_tf_before_wrap", 32'h0);
        step(180);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfA[0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t2_cnt_wrap", 32'h0); push_exp("t2_tf_set", 32'h1); push_exp("t2_irq_lags", 32'h0);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfA[0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, irqA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t2_irq_set", 32'h1);
        step(1);
        obs = {31'h0, irqA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tfClr = 2'b01;
        push_exp("t2_tf_cleared", 32'h0); push_exp("t2_irq_still_set", 32'h1);
        step(1);
        tfClr = 2'b00;
        obs = {31'h0, tfA[0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, irqA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t2_irq_cleared", 32'h0);
        step(1);
        obs = {31'h0, irqA}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tr = 2'b00;
    endtask

    task automatic test_auto_reload();
        logic [31:0] obs;
        exp_t e;
        tr = 2'b00; mode = 4'b0100; reloadIn[31:16] = 16'hFF00;
        wait_phase(11);
        load = 2'b10; cntIn[31:16] = 16'hFFFE;
        step(1);
        load = 2'b00; tr = 2'b10;
        push_exp("t3_first_tick", 32'hFFFF);
        step(12);
        obs = {16'h0, cntA[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t3_reload_ff00", 32'hFF00); push_exp("t3_tf1_set", 32'h1);
        step(12);
        obs = {16'h0, cntA[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfA[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t3_after_reload", 32'hFF01);
        step(12);
        obs = {16'h0, cntA[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        reloadIn[31:16] = 16'h1234; tfClr = 2'b10;
        push_exp("t3_tf1_cleared", 32'h0);
        step(1);
        tfClr = 2'b00;
        obs = {31'h0, tfA[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t3_reach_ffff", 32'hFFFF);
        step(12 * 254 - 1);
        obs = {16'h0, cntA[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t3_new_reload", 32'h1234); push_exp("t3_tf1_again", 32'h1);
        step(12);
        obs = {16'h0, cntA[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfA[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tr = 2'b00; mode = 4'b0000;
    endtask

    task automatic test_one_shot();
        logic [31:0] obs;
        exp_t e;
        tfClr = 2'b11; mode = 4'b0010; tr = 2'b00;
        step(1);
        tfClr = 2'b00;
        wait_phase(11);
        load = 2'b01; cntIn[15:0] = 16'hFFFF;
        step(1);
        load = 2'b00; tr = 2'b01;
        push_exp("t4_wrap_zero", 32'h0); push_exp("t4_tf0_set", 32'h1);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfA[0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t4_halted_100_ticks", 32'h0);
        step(1200);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tr = 2'b00;
        step(1);
        tr = 2'b01;
        wait_phase(11);
        push_exp("t4_resumed_by_tr", 32'h1);
        step(1);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        wait_phase(11);
        load = 2'b01; cntIn[15:0] = 16'hFFFF;
        push_exp("t4_load_beats_tick", 32'hFFFF);
        step(1);
        load = 2'b00;
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t4_second_wrap", 32'h0);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t4_halted_again", 32'h0);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        load = 2'b01; cntIn[15:0] = 16'hFFFF;
        push_exp("t4_load_while_done", 32'hFFFF);
        step(1);
        load = 2'b00;
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t4_resumed_by_load", 32'h0);
        step(11);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tr = 2'b00; mode = 4'b0000;
    endtask

    task automatic test_gate();
        logic [31:0] obs;
        exp_t e;
        tfClr = 2'b11; gate = 2'b01; intPin = 2'b00; mode = 4'b0000; tr = 2'b00;
        step(1);
        tfClr = 2'b00; load = 2'b01; cntIn[15:0] = 16'h0000;
        step(1);
        load = 2'b00; tr = 2'b01;
        push_exp("t5_gated_50_ticks", 32'h0);
        step(600);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        wait_phase(10);
        intPin = 2'b01;
        push_exp("t5_sync_latency", 32'h0);
        step(2);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t5_counting", 32'h1);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t5_counting_more", 32'h2);
        step(12);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        wait_phase(9);
        intPin = 2'b00;
        push_exp("t5_stopped", 32'h2);
        step(3);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        push_exp("t5_still_stopped", 32'h2);
        step(36);
        obs = {16'h0, cntA[15:0]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        gate = 2'b00; tr = 2'b00;
    endtask

    task automatic test_tx_counter();
        logic [31:0] obs;
        exp_t e;
        logic [15:0] seq [5];
        logic [15:0] prevCnt;
        seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        ct = 2'b10; mode = 4'b0000; gate = 2'b00; intPin = 2'b00; txPin = 2'b11;
        tfClr = 2'b11; load = 2'b10; cntIn[31:16] = 16'hFFFD; tr = 2'b10;
        push_exp("t6_loaded", 32'hFFFD); push_exp("t6_tf1_clear", 32'h0);
        step(1);
        tfClr = 2'b00; load = 2'b00;
        obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfB[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        prevCnt = 16'hFFFD;
        for (int i = 0; i < 5; i++) begin
            txPin[1] = 1'b0;
            push_exp("t6_no_early_inc", {16'h0, prevCnt});
            push_exp("t6_inc_3clk_after_edge", {16'h0, seq[i]});
            step(2);
            obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
            if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
            step(1);
            obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
            if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
            prevCnt = seq[i];
            step(1);
            txPin[1] = 1'b1;
            step(4);
        end
        push_exp("t6_tf1_after_wrap", 32'h1);
        obs = {31'h0, tfB[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end

        tfClr = 2'b10; load = 2'b10; cntIn[31:16] = 16'hFFFF;
        push_exp("t6_tf1_cleared", 32'h0);
        step(1);
        tfClr = 2'b00; load = 2'b00;
        obs = {31'h0, tfB[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        txPin[1] = 1'b0;
        step(2);
        tfClr = 2'b10;
        push_exp("t6_wrap_with_clr_cnt", 32'h0); push_exp("t6_set_beats_clr", 32'h1);
        step(1);
        tfClr = 2'b00;
        obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        obs = {31'h0, tfB[1]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        step(1);
        txPin[1] = 1'b1;
        step(4);

        txPin[1] = 1'b0;
        step(2);
        load = 2'b10; cntIn[31:16] = 16'h00AA;
        push_exp("t6_load_beats_event", 32'h00AA);
        step(1);
        load = 2'b00;
        obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        step(1);
        txPin[1] = 1'b1;
        push_exp("t6_no_late_inc", 32'h00AA);
        step(4);
        obs = {16'h0, cntB[31:16]}; e = sb.pop_front(); checks++;
        if (obs !== e.value) begin failures++; $display("[TB] FAIL %s got=%h want=%h", e.name, obs, e.value); end
        tr = 2'b00; ct = 2'b00;
    endtask

    initial begin
        reset = 1'b1; intPin = 2'b00; txPin = 2'b11; gate = 2'b00; ct = 2'b00;
        mode = 4'b0000; tr = 2'b00; load = 2'b00; tfClr = 2'b00;
        cntIn = 32'h0; reloadIn = 32'h0;
        test_reset();
        test_free_run_overflow();
        test_auto_reload();
        test_one_shot();
        test_gate();
        test_tx_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
